// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, reset PC and NOP word.
package mips_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Output slot toward IF/ID: holds {pc, instr} while the consumer stalls, cleared on flush.
module fetch_out_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic        o_free,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= NOP_WORD;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_free  = !r_valid || i_ready;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ack, feeds IF/ID over valid/ready.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_mem_wait_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic [31:0] out_instr
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_drop_addr;
    logic [31:0]  w_drop_addr_next;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;
    logic         w_slot_free;
    logic         w_capture;
    logic         w_flush;

    assign w_pc_inc = r_pc + STEP;
    assign w_target = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StBoot;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_drop_addr <= w_drop_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_drop_addr_next = r_drop_addr;
        w_capture        = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            StBoot: begin
                w_state_next = StRun;
                if (redirect_valid) w_pc_next = w_target;
            end
            StRun: begin
                if (redirect_valid) begin
                    w_flush   = 1'b1;
                    w_pc_next = w_target;
                    // An unacknowledged request must still complete before the new stream starts.
                    if (imem_req && !imem_ack) begin
                        w_state_next     = StDrop;
                        w_drop_addr_next = r_pc;
                    end
                end else if (imem_req && imem_ack) begin
                    w_capture = 1'b1;
                    w_pc_next = w_pc_inc;
                end else if (imem_req) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (redirect_valid) begin
                    w_flush          = 1'b1;
                    w_pc_next        = w_target;
                    w_state_next     = StDrop;
                    w_drop_addr_next = r_pc;
                end else if (imem_ack) begin
                    w_capture    = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = StRun;
                end
            end
            StDrop: begin
                if (redirect_valid) begin
                    w_flush   = 1'b1;
                    w_pc_next = w_target;
                end else if (imem_ack) begin
                    w_state_next = StRun;
                end
            end
            default: w_state_next = StBoot;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        case (r_state)
            StBoot: imem_req = 1'b0;
            StRun:  imem_req = w_slot_free;
            StWait: imem_req = 1'b1;
            StDrop: begin
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    fetch_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_capture),
        .i_flush (w_flush),
        .i_ready (out_ready),
        .i_pc    (w_pc_inc),
        .i_instr (imem_rdata),
        .o_valid (out_valid),
        .o_free  (w_slot_free),
        .o_pc    (out_pc),
        .o_instr (out_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
            r_wait_cnt  <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (imem_req && !imem_ack && (r_wait_cnt != 32'hFFFF_FFFF)) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (redirect_valid && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = r_stall_cnt;
    assign perf_mem_wait_cnt = r_wait_cnt;
    assign perf_flush_cnt    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream
// checked against a transaction-level model of the expected instruction sequence.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_mem_wait_cnt;
    logic [31:0] perf_flush_cnt;
    int unsigned m_stall;
    int unsigned m_wait;
    int unsigned m_flush;
`endif

    int tests_run;
    int tests_failed;

    // Values observed during the most recent drive() cycle, before its clock edge.
    logic        last_req;
    logic        last_ack;
    logic [31:0] last_addr;
    logic        pre_valid;
    logic [31:0] pre_pc;
    logic [31:0] pre_instr;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_mem_wait_cnt (perf_mem_wait_cnt),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .out_instr         (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // One clock cycle: apply inputs after the negedge, answer memory, advance to next negedge.
    task automatic drive(input logic rdy, input logic ack, input logic redir,
                         input logic [31:0] rpc);
        pre_valid      = out_valid;
        pre_pc         = out_pc;
        pre_instr      = out_instr;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        last_req   = imem_req;
        last_addr  = imem_addr;
        imem_ack   = ack && imem_req;
        last_ack   = imem_ack;
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
`ifdef FETCH_PERF_CNT_EN
        if (pre_valid && !rdy) m_stall++;
        if (last_req && !last_ack) m_wait++;
        if (redir) m_flush++;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_stall = 0;
        m_wait  = 0;
        m_flush = 0;
`endif
        drive(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({imem_req, out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_req_valid: got %b want 00", {imem_req, out_valid});
        end
        tests_run++;
        if ({imem_addr, out_pc, out_instr} !== {RESET_PC, 64'h0}) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h/%h/%h want %h/0/0", imem_addr, out_pc,
                     out_instr, RESET_PC);
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_req !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_req: got req=%b valid=%b want 0/0", last_req, out_valid);
        end
    endtask

    task automatic test_sequential();
        // Continues from test_reset: now in the first RUN cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (last_req !== 1'b1 || last_addr !== RESET_PC + 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL seq_req%0d: got req=%b addr=%h want 1/%h", i, last_req,
                         last_addr, RESET_PC + 32'(4 * i));
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * i + 4) ||
                out_instr !== mem_word(RESET_PC + 32'(4 * i))) begin
                tests_failed++;
                $display("FAIL seq_out%0d: got v=%b pc=%h ins=%h want 1/%h/%h", i, out_valid,
                         out_pc, out_instr, RESET_PC + 32'(4 * i + 4),
                         mem_word(RESET_PC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_mem_wait();
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tests_run++;
            if (last_req !== 1'b1 || last_addr !== 32'h3004 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_hold%0d: got req=%b addr=%h v=%b want 1/3004/0", i,
                         last_req, last_addr, out_valid);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_addr !== 32'h3004 || out_valid !== 1'b1 || out_pc !== 32'h3008 ||
            out_instr !== mem_word(32'h3004)) begin
            tests_failed++;
            $display("FAIL wait_done: got addr=%h v=%b pc=%h want 3004/1/3008", last_addr,
                     out_valid, out_pc);
        end
    endtask

    task automatic test_stall();
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            tests_run++;
            if (last_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h3004 ||
                out_instr !== mem_word(32'h3000)) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got req=%b v=%b pc=%h ins=%h want 0/1/3004/%h", i,
                         last_req, out_valid, out_pc, out_instr, mem_word(32'h3000));
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_req !== 1'b1 || last_addr !== 32'h3004 || out_pc !== 32'h3008) begin
            tests_failed++;
            $display("FAIL stall_resume: got req=%b addr=%h pc=%h want 1/3004/3008", last_req,
                     last_addr, out_pc);
        end
    endtask

    task automatic test_redirect_wait();
        reset_dut();
        repeat (4) drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h4002);
        tests_run++;
        if (last_addr !== 32'h3010 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdw_redirect: got addr=%h v=%b want 3010/0", last_addr, out_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (last_req !== 1'b1 || last_addr !== 32'h3010) begin
            tests_failed++;
            $display("FAIL rdw_old_held: got req=%b addr=%h want 1/3010", last_req, last_addr);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_addr !== 32'h3010 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdw_discard: got addr=%h v=%b want 3010/0", last_addr, out_valid);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_addr !== 32'h4000 || out_valid !== 1'b1 || out_pc !== 32'h4004 ||
            out_instr !== mem_word(32'h4000)) begin
            tests_failed++;
            $display("FAIL rdw_target: got addr=%h v=%b pc=%h want 4000/1/4004", last_addr,
                     out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_ack();
        reset_dut();
        drive(1'b1, 1'b1, 1'b1, 32'h5000);
        tests_run++;
        if (last_ack !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rda_flush: got ack=%b v=%b want 1/0", last_ack, out_valid);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_addr !== 32'h5000 || out_pc !== 32'h5004 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rda_target: got addr=%h pc=%h v=%b want 5000/5004/1", last_addr,
                     out_pc, out_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        reset_dut();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tests_run++;
        if (last_addr !== 32'hFFFF_FFFC || out_pc !== 32'h0 ||
            out_instr !== mem_word(32'hFFFF_FFFC)) begin
            tests_failed++;
            $display("FAIL wrap_out: got addr=%h pc=%h want fffffffc/0", last_addr, out_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next: got req=%b addr=%h want 1/0", last_req, last_addr);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got req=%b addr=%h v=%b want 0/%h/0", imem_req,
                     imem_addr, out_valid, RESET_PC);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;
        logic [31:0] hold_addr;
        logic [31:0] rpc;
        logic        pend_hold;
        logic        pend_mem;
        logic        rdy;
        logic        ack;
        logic        redir;
        int          delivered;
        reset_dut();
        exp_next   = RESET_PC;
        pend_hold  = 1'b0;
        pend_mem   = 1'b0;
        hold_pc    = 32'h0;
        hold_instr = 32'h0;
        hold_addr  = 32'h0;
        delivered  = 0;
        for (int c = 0; c < 800; c++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            ack   = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 39) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if (pend_hold) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_pc !== hold_pc || out_instr !== hold_instr) begin
                    tests_failed++;
                    $display("FAIL rnd_stable c%0d: got v=%b pc=%h ins=%h want 1/%h/%h", c,
                             out_valid, out_pc, out_instr, hold_pc, hold_instr);
                end
            end
            drive(rdy, ack, redir, rpc);
            if (pend_mem) begin
                tests_run++;
                if (last_req !== 1'b1 || last_addr !== hold_addr) begin
                    tests_failed++;
                    $display("FAIL rnd_req_hold c%0d: got req=%b addr=%h want 1/%h", c,
                             last_req, last_addr, hold_addr);
                end
            end
            if (pre_valid && rdy) begin
                tests_run++;
                if (pre_pc !== exp_next + 32'd4 || pre_instr !== mem_word(exp_next)) begin
                    tests_failed++;
                    $display("FAIL rnd_xfer c%0d: got pc=%h ins=%h want %h/%h", c, pre_pc,
                             pre_instr, exp_next + 32'd4, mem_word(exp_next));
                end
                exp_next = exp_next + 32'd4;
                delivered++;
            end
            if (redir) begin
                exp_next = {rpc[31:2], 2'b00};
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rnd_flush c%0d: got v=%b want 0", c, out_valid);
                end
            end
            pend_hold  = pre_valid && !rdy && !redir;
            hold_pc    = pre_pc;
            hold_instr = pre_instr;
            pend_mem   = last_req && !last_ack;
            hold_addr  = last_addr;
        end
        tests_run++;
        if (delivered < 50) begin
            tests_failed++;
            $display("FAIL rnd_throughput: got %0d transfers want >= 50", delivered);
        end
`ifdef FETCH_PERF_CNT_EN
        tests_run++;
        if (perf_stall_cnt !== 32'(m_stall) || perf_mem_wait_cnt !== 32'(m_wait) ||
            perf_flush_cnt !== 32'(m_flush)) begin
            tests_failed++;
            $display("FAIL perf_cnt: got %0d/%0d/%0d want %0d/%0d/%0d", perf_stall_cnt,
                     perf_mem_wait_cnt, perf_flush_cnt, m_stall, m_wait, m_flush);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
